// File: rtl/regbank_wr_slicer_if.sv
// Bus interface for the register-bank write slicer.
//   we, wa, wd  : write request, 5-bit register address, WIDTH-bit data
//   scrub_req   : request a sequential clear of r1..r31
//   busy        : scrub in progress (writes are dropped while high)
//   wr_ack      : one-cycle registered pulse after every accepted write
//   slices      : bit-sliced bank, slices[b*32 + r] = bit b of register r
// master drives requests and write data; slave (the bank) drives status and slices.
interface regbank_wr_slicer_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic                  we;
  logic [4:0]            wa;
  logic [WIDTH-1:0]      wd;
  logic                  scrub_req;
  logic                  busy;
  logic                  wr_ack;
  logic [32*WIDTH-1:0]   slices;

  modport master (
    output we, wa, wd, scrub_req,
    input  busy, wr_ack, slices
  );

  modport slave (
    input  we, wa, wd, scrub_req,
    output busy, wr_ack, slices
  );
endinterface

// File: rtl/regbank_wr_slicer.sv
// Write side of the CPU register bank.
// Holds 32 registers of WIDTH bits (r0 hardwired to zero), decodes the write address into
// one-hot enables and presents the contents bit-sliced for the per-bit 32:1 read selectors.
// A scrub engine zeroes r1..r31 one register per cycle without using reset.
// Ports:
//   clk_i : system clock, all state updates on the rising edge
//   clr_i : synchronous active-high reset, overrides everything including a running scrub
//   bus   : slave side of regbank_wr_slicer_if (we/wa/wd/scrub_req in, busy/wr_ack/slices out)
module regbank_wr_slicer #(
  parameter int unsigned WIDTH = 32
) (
  input logic                clk_i,
  input logic                clr_i,
  regbank_wr_slicer_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StScrub} state_e;

  state_e           state_q;
  logic [4:0]       cnt_q;
  logic             busy_q;
  logic             wr_ack_q;
  logic             wr_ack_d;
  logic [31:0]      wr_en;

  logic [WIDTH-1:0] regs_q [1:31];
  logic [WIDTH-1:0] regs_d [1:31];

  // One-hot write enables; bit 0 still decodes so a write to r0 is acknowledged.
  always_comb begin
    wr_en = '0;
    if (bus.we && !busy_q) begin
      wr_en[bus.wa] = 1'b1;
    end
  end

  assign wr_ack_d = |wr_en;

  // Writes and scrub clears never coincide: the scrub only runs while busy blocks writes.
  always_comb begin
    for (int r = 1; r < 32; r++) begin
      regs_d[r] = regs_q[r];
      if (wr_en[r]) begin
        regs_d[r] = bus.wd;
      end
      if (state_q == StScrub && cnt_q == 5'(r)) begin
        regs_d[r] = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      for (int r = 1; r < 32; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      for (int r = 1; r < 32; r++) begin
        regs_q[r] <= regs_d[r];
      end
    end
  end

  // Scrub FSM with registered busy/wr_ack; the counter runs 1..31 and never wraps through 0.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      wr_ack_q <= 1'b0;
    end else begin
      wr_ack_q <= wr_ack_d;
      unique case (state_q)
        StIdle: begin
          if (bus.scrub_req) begin
            state_q <= StScrub;
            cnt_q   <= 5'd1;
            busy_q  <= 1'b1;
          end
        end
        StScrub: begin
          if (cnt_q == 5'd31) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.wr_ack = wr_ack_q;

  for (genvar b = 0; b < WIDTH; b++) begin : g_slice
    assign bus.slices[b*32] = 1'b0;
    for (genvar r = 1; r < 32; r++) begin : g_reg
      assign bus.slices[b*32 + r] = regs_q[r][b];
    end
  end

endmodule

// File: tb/tb_regbank_wr_slicer.sv
module tb_regbank_wr_slicer;

  logic clk;
  logic clr;

  regbank_wr_slicer_if #(.WIDTH(32)) bus ();

  regbank_wr_slicer #(.WIDTH(32)) dut (
    .clk_i (clk),
    .clr_i (clr),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: register contents, next register the scrub will zero (0 = idle).
  logic [31:0] mdl_mem [32];
  int          scrub_next = 0;
  logic        mdl_ack = 1'b0;
  bit          valid = 1'b0;
  bit          acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] reg_of(input int r);
    logic [31:0] v;
    for (int b = 0; b < 32; b++) v[b] = bus.slices[b*32 + r];
    return v;
  endfunction

  always @(posedge clk) begin
    if (clr) begin
      for (int r = 0; r < 32; r++) mdl_mem[r] = '0;
      scrub_next = 0;
      mdl_ack    = 1'b0;
      valid      = 1'b1;
    end else if (valid) begin
      acc     = bus.we && (scrub_next == 0);
      mdl_ack = acc;
      if (scrub_next != 0) begin
        mdl_mem[scrub_next] = '0;
        scrub_next = (scrub_next == 31) ? 0 : scrub_next + 1;
      end else if (bus.scrub_req) begin
        scrub_next = 1;
      end
      if (acc && bus.wa != 5'd0) mdl_mem[bus.wa] = bus.wd;
    end
  end

  always @(negedge clk) begin
    if (valid) begin
      chk("busy", {31'd0, bus.busy}, {31'd0, scrub_next != 0});
      chk("wr_ack", {31'd0, bus.wr_ack}, {31'd0, mdl_ack});
      for (int r = 0; r < 32; r++) chk($sformatf("slice_r%0d", r), reg_of(r), mdl_mem[r]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] d);
    bus.we = 1'b1;
    bus.wa = a;
    bus.wd = d;
    tick();
    bus.we = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    clr           = 1'b1;
    bus.we        = 1'b0;
    bus.wa        = '0;
    bus.wd        = '0;
    bus.scrub_req = 1'b0;
    tick();
    tick();
    clr = 1'b0;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_ack", {31'd0, bus.wr_ack}, 32'd0);
    chk("rst_ones", $countones(bus.slices), 32'd0);

    // Reset after a write clears everything
    write(5'd5, 32'hA5A5_A5A5);
    chk("wr5_ack", {31'd0, bus.wr_ack}, 32'd1);
    chk("wr5_val", reg_of(5), 32'hA5A5_A5A5);
    clr = 1'b1;
    tick();
    tick();
    clr = 1'b0;
    chk("clr_ones", $countones(bus.slices), 32'd0);
    chk("clr_busy", {31'd0, bus.busy}, 32'd0);
    chk("clr_ack", {31'd0, bus.wr_ack}, 32'd0);

    // Back-to-back writes and slice mapping
    bus.we = 1'b1;
    bus.wa = 5'd3;
    bus.wd = 32'h0000_0001;
    tick();
    chk("b2b_ack1", {31'd0, bus.wr_ack}, 32'd1);
    bus.wa = 5'd31;
    bus.wd = 32'h8000_0000;
    tick();
    chk("b2b_ack2", {31'd0, bus.wr_ack}, 32'd1);
    bus.we = 1'b0;
    tick();
    chk("b2b_ack_end", {31'd0, bus.wr_ack}, 32'd0);
    chk("slice_0_3", {31'd0, bus.slices[0*32 + 3]}, 32'd1);
    chk("slice_31_31", {31'd0, bus.slices[31*32 + 31]}, 32'd1);
    chk("map_ones", $countones(bus.slices), 32'd2);

    // r0 stays zero but the write is acknowledged
    write(5'd0, 32'hFFFF_FFFF);
    chk("r0_ack", {31'd0, bus.wr_ack}, 32'd1);
    chk("r0_val", reg_of(0), 32'd0);
    chk("r0_ones", $countones(bus.slices), 32'd2);

    // Fill and scrub, with a dropped mid-scrub write
    for (int r = 1; r < 32; r++) write(5'(r), 32'hFFFF_FFFF);
    tick();
    chk("fill_ones", $countones(bus.slices), 32'd992);
    bus.scrub_req = 1'b1;
    tick();
    bus.scrub_req = 1'b0;
    n = 0;
    while (bus.busy && n < 100) begin
      if (n == 5) begin
        bus.we = 1'b1;
        bus.wa = 5'd7;
        bus.wd = 32'h1234_5678;
      end
      tick();
      n++;
      bus.we = 1'b0;
      if (n == 6) begin
        chk("drop_ack", {31'd0, bus.wr_ack}, 32'd0);
        chk("drop_r7", reg_of(7), 32'hFFFF_FFFF);
      end
    end
    chk("scrub_len", n, 32'd31);
    chk("scrub_ones", $countones(bus.slices), 32'd0);

    // Simultaneous write and scrub request
    bus.we        = 1'b1;
    bus.wa        = 5'd9;
    bus.wd        = 32'h0000_0055;
    bus.scrub_req = 1'b1;
    tick();
    bus.we        = 1'b0;
    bus.scrub_req = 1'b0;
    chk("sim_ack", {31'd0, bus.wr_ack}, 32'd1);
    chk("sim_r9", reg_of(9), 32'h0000_0055);
    n = 0;
    while (bus.busy && n < 100) begin
      tick();
      n++;
      if (n == 8) chk("sim_r9_kept", reg_of(9), 32'h0000_0055);
      if (n == 9) chk("sim_r9_zero", reg_of(9), 32'd0);
    end
    chk("sim_len", n, 32'd31);

    // Reset on scrub cycle 10, then a full restart
    write(5'd4, 32'hDEAD_BEEF);
    write(5'd20, 32'hCAFE_F00D);
    bus.scrub_req = 1'b1;
    tick();
    bus.scrub_req = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("mid_busy", {31'd0, bus.busy}, 32'd1);
    chk("mid_r20", reg_of(20), 32'hCAFE_F00D);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("mid_clr_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_clr_ones", $countones(bus.slices), 32'd0);
    bus.scrub_req = 1'b1;
    tick();
    bus.scrub_req = 1'b0;
    n = 0;
    while (bus.busy && n < 100) begin
      tick();
      n++;
    end
    chk("restart_len", n, 32'd31);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bus.we        = 1'($urandom_range(0, 1));
      bus.wa        = 5'($urandom);
      bus.wd        = $urandom;
      bus.scrub_req = ($urandom_range(0, 39) == 0);
      clr           = ($urandom_range(0, 199) == 0);
      tick();
    end
    bus.we        = 1'b0;
    bus.scrub_req = 1'b0;
    clr           = 1'b0;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
